// File: rtl/sine_dds.sv
// Phase-accumulator sine generator with quarter-wave LUT, 3-stage pipeline and valid/ready output.
// Optional cosine output enabled by defining SINE_DDS_COSINE_EN.
module sine_dds #(
  parameter int unsigned OUT_WIDTH      = 8,
  parameter int unsigned ACC_WIDTH      = 16,
  parameter int unsigned LUT_ADDR_WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync,
  input  logic [ACC_WIDTH-1:0] freq_word,
  input  logic [ACC_WIDTH-1:0] phase_offset,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] sine
`ifdef SINE_DDS_COSINE_EN
  ,
  output logic [OUT_WIDTH-1:0] cosine
`endif
);

  localparam int unsigned Q       = 2 ** LUT_ADDR_WIDTH;
  localparam int unsigned AMP     = 2 ** (OUT_WIDTH - 1) - 1;
  localparam int unsigned PH_BITS = LUT_ADDR_WIDTH + 2;

  // round(AMP*sin(pi/2*(k+0.5)/Q)) in 2^30 fixed point (Taylor series to x^13)
  function automatic logic [OUT_WIDTH-1:0] lut_val(input int unsigned k);
    longint x;
    longint term;
    longint sum;
    longint prod;
    x    = (64'sd1686629713 * longint'(2 * k + 1)) / longint'(2 * Q);
    term = x;
    sum  = x;
    for (int n = 1; n <= 6; n++) begin
      prod = (((term * x) >>> 30) * x) >>> 30;
      term = -(prod / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    return OUT_WIDTH'((longint'(AMP) * sum + 64'sd536870912) >>> 30);
  endfunction

  logic [OUT_WIDTH-1:0] lut [Q];

  for (genvar k = 0; k < Q; k++) begin : g_lut
    localparam logic [OUT_WIDTH-1:0] VAL = lut_val(k);
    assign lut[k] = VAL;
  end

  logic [ACC_WIDTH-1:0]      acc;
  logic [1:0]                fill;
  logic [PH_BITS-1:0]        ph1;
  logic [LUT_ADDR_WIDTH-1:0] addr_s;
  logic                      neg_s;
  logic [LUT_ADDR_WIDTH-1:0] q1;
  logic [1:0]                quad1;
  logic [OUT_WIDTH-1:0]      mag_s;
  logic                      adv;

  assign adv   = enable & (~out_valid | out_ready);
  assign q1    = ph1[LUT_ADDR_WIDTH-1:0];
  assign quad1 = ph1[PH_BITS-1 -: 2];
  assign mag_s = lut[addr_s];

`ifdef SINE_DDS_COSINE_EN
  logic [LUT_ADDR_WIDTH-1:0] addr_c;
  logic                      neg_c;
  logic [OUT_WIDTH-1:0]      mag_c;

  assign mag_c = lut[addr_c];

  // Cosine is the next quadrant: sign flips in quadrants 1,2 and the fold direction inverts
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_c <= '0;
      neg_c  <= 1'b0;
      cosine <= '0;
    end else if (!sync && adv) begin
      addr_c <= quad1[0] ? q1 : ~q1;
      neg_c  <= quad1[1] ^ quad1[0];
      cosine <= neg_c ? ('0 - mag_c) : mag_c;
    end
  end
`endif

  // Accumulator, fill tracking and sine pipeline; only the phase bits the LUT needs are kept in S1
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc       <= '0;
      fill      <= 2'd0;
      out_valid <= 1'b0;
      ph1       <= '0;
      addr_s    <= '0;
      neg_s     <= 1'b0;
      sine      <= '0;
    end else if (sync) begin
      acc       <= '0;
      fill      <= 2'd0;
      out_valid <= 1'b0;
    end else if (adv) begin
      acc       <= acc + freq_word;
      fill      <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
      out_valid <= (fill >= 2'd2);
      ph1       <= PH_BITS'((acc + phase_offset) >> (ACC_WIDTH - PH_BITS));
      addr_s    <= quad1[0] ? ~q1 : q1;
      neg_s     <= quad1[1];
      sine      <= neg_s ? ('0 - mag_s) : mag_s;
    end
  end

endmodule

// File: tb/tb_sine_dds.sv
// Directed bench for sine_dds: fill latency, backpressure, sync, freeze, offsets, reset and wrap.
module tb_sine_dds;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        sync;
  logic [15:0] freq_word;
  logic [15:0] phase_offset;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  sine;
`ifdef SINE_DDS_COSINE_EN
  logic [7:0]  cosine;
`endif

  int n_cmp;
  int n_bad;

  sine_dds dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sync         (sync),
    .freq_word    (freq_word),
    .phase_offset (phase_offset),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .sine         (sine)
`ifdef SINE_DDS_COSINE_EN
    ,
    .cosine       (cosine)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int exp_s [5] = '{2, 127, -2, -127, 2};
  int exp_c [5] = '{127, -2, -127, 2, 127};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0; enable = 1'b0; sync = 1'b0;
    freq_word = 16'h0000; phase_offset = 16'h0000; out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_sine", $signed(sine), 0);
`ifdef SINE_DDS_COSINE_EN
    check("rst_cos", $signed(cosine), 0);
`endif

    // ramp through the first LUT entries
    reset = 1'b1; enable = 1'b1; freq_word = 16'h0100;
    tick(); check("fill1_valid", out_valid, 0);
    tick(); check("fill2_valid", out_valid, 0);
    tick(); check("fill3_valid", out_valid, 1);
    check("ramp0", $signed(sine), 2);
    tick(); check("ramp1", $signed(sine), 5);
    tick(); check("ramp2", $signed(sine), 8);

    // backpressure holds the sample, then the ramp resumes without a gap
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sine", $signed(sine), 8);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick(); check("ramp3", $signed(sine), 11);
    tick(); check("ramp4", $signed(sine), 14);

    // sync mid-stream, then quarter-turn steps
    sync = 1'b1; freq_word = 16'h4000;
    tick();
    sync = 1'b0;
    check("sync_valid", out_valid, 0);
    tick();
    tick(); check("sync_fill_valid", out_valid, 0);
    tick(); check("sync_ref_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("quad_sine", $signed(sine), exp_s[i]);
`ifdef SINE_DDS_COSINE_EN
      check("quad_cos", $signed(cosine), exp_c[i]);
`endif
    end

    // enable low freezes everything
    enable = 1'b0;
    tick();
    tick();
    check("frz_sine", $signed(sine), 2);
    check("frz_valid", out_valid, 1);

    // sync still clears while disabled; then constant output at 90 degrees
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_dis_valid", out_valid, 0);
    enable = 1'b1; freq_word = 16'h0000; phase_offset = 16'h4000;
    tick();
    tick();
    tick(); check("off90_valid", out_valid, 1);
    check("off90_a", $signed(sine), 127);
    tick(); check("off90_b", $signed(sine), 127);

    // new offset takes three advances to reach the output
    phase_offset = 16'h8000;
    tick();
    tick(); check("off180_old", $signed(sine), 127);
    tick(); check("off180_a", $signed(sine), -2);
    tick(); check("off180_b", $signed(sine), -2);

    // reset during backpressure
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sine", $signed(sine), 0);
`ifdef SINE_DDS_COSINE_EN
    check("mid_rst_cos", $signed(cosine), 0);
`endif

    // negative step via wrap-around
    reset = 1'b1; out_ready = 1'b1; freq_word = 16'hFFFF; phase_offset = 16'h0000;
    tick();
    tick();
    tick(); check("wrap_valid", out_valid, 1);
    check("wrap0", $signed(sine), 2);
    tick(); check("wrap1", $signed(sine), -2);
    tick(); check("wrap2", $signed(sine), -2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
